// File: rtl/cmd_decode.sv
// cmd_decode: bit-serial reader for the G-15 command register track (CM), presenting the command fields in parallel.
// Optional special-command decode (DS, S_OH) is built only when G15_SPECIAL_DECODE_EN is defined.
module cmd_decode (
    input  logic        CLOCK,
    input  logic        rst_n,
    input  logic        CM,
    input  logic        WORD_SYNC,
    input  logic        LATCH,
    output logic [4:0]  BITT,
    output logic        SYNCED,
    output logic        VALID,
    output logic        PREFIX,
    output logic [4:0]  D,
    output logic [4:0]  S,
    output logic [1:0]  C,
    output logic [6:0]  N,
    output logic        BP,
    output logic [6:0]  T,
    output logic        ID,
    output logic        DS,
    output logic [31:0] S_OH,
    output logic        SYNC_ERR
);

    // The lowest shift-register stage is only ever shifted out, so bits 28..1 are all that is stored.
    logic [28:1] sr;
    logic [28:0] word;
    logic [4:0]  bitt_next;
    logic        capture;

    assign word    = {CM, sr[28:1]};
    assign capture = LATCH && SYNCED && (BITT == 5'd29);

    always_comb begin
        bitt_next = BITT;
        if (WORD_SYNC) begin
            bitt_next = 5'd1;
        end else if (BITT == 5'd29) begin
            bitt_next = 5'd1;
        end else if (BITT != 5'd0) begin
            bitt_next = BITT + 5'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= word[28:1];
        end
    end

    // A slipped WORD_SYNC is flagged but still wins: the counter realigns to it.
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            BITT     <= 5'd0;
            SYNCED   <= 1'b0;
            SYNC_ERR <= 1'b0;
        end else begin
            BITT <= bitt_next;
            if (WORD_SYNC) begin
                SYNCED <= 1'b1;
            end
            if (WORD_SYNC && SYNCED && (BITT != 5'd29)) begin
                SYNC_ERR <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            VALID  <= 1'b0;
            PREFIX <= 1'b0;
            D      <= 5'd0;
            S      <= 5'd0;
            C      <= 2'd0;
            N      <= 7'd0;
            BP     <= 1'b0;
            T      <= 7'd0;
            ID     <= 1'b0;
        end else begin
            VALID <= capture;
            if (capture) begin
                PREFIX <= word[0];
                D      <= word[5:1];
                S      <= word[10:6];
                C      <= word[12:11];
                N      <= word[19:13];
                BP     <= word[20];
                T      <= word[27:21];
                ID     <= word[28];
            end
        end
    end

`ifdef G15_SPECIAL_DECODE_EN
    logic special;

    assign special = (word[5:1] == 5'd31);

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            DS   <= 1'b0;
            S_OH <= '0;
        end else if (capture) begin
            DS   <= special;
            S_OH <= special ? (32'd1 << word[10:6]) : 32'd0;
        end
    end
`else
    assign DS   = 1'b0;
    assign S_OH = 32'd0;
`endif

endmodule

// File: tb/tb_cmd_decode.sv
// tb_cmd_decode: self-checking bench for cmd_decode; captured words are queued on LATCH and matched on VALID.
// Honours G15_SPECIAL_DECODE_EN for the expected DS / S_OH values.
module tb_cmd_decode;

    logic        CLOCK;
    logic        rst_n;
    logic        CM;
    logic        WORD_SYNC;
    logic        LATCH;
    logic [4:0]  BITT;
    logic        SYNCED;
    logic        VALID;
    logic        PREFIX;
    logic [4:0]  D;
    logic [4:0]  S;
    logic [1:0]  C;
    logic [6:0]  N;
    logic        BP;
    logic [6:0]  T;
    logic        ID;
    logic        DS;
    logic [31:0] S_OH;
    logic        SYNC_ERR;

    int checks = 0;
    int errors = 0;
    logic [28:0] sb_q[$];
    logic [28:0] w1, w2, w3, w4, w5, w6;

    cmd_decode dut (
        .CLOCK(CLOCK), .rst_n(rst_n), .CM(CM), .WORD_SYNC(WORD_SYNC), .LATCH(LATCH),
        .BITT(BITT), .SYNCED(SYNCED), .VALID(VALID), .PREFIX(PREFIX), .D(D), .S(S),
        .C(C), .N(N), .BP(BP), .T(T), .ID(ID), .DS(DS), .S_OH(S_OH), .SYNC_ERR(SYNC_ERR)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    function automatic logic [28:0] make_word(input logic prefix, input logic [4:0] d, input logic [4:0] s,
                                              input logic [1:0] c, input logic [6:0] n, input logic bp,
                                              input logic [6:0] t, input logic id);
        return {id, t, bp, n, c, s, d, prefix};
    endfunction

    function automatic logic [32:0] special_of(input logic [28:0] w);
        logic [32:0] r;
        r = '0;
`ifdef G15_SPECIAL_DECODE_EN
        if (w[5:1] == 5'd31) r = {1'b1, 32'd1 << w[10:6]};
`endif
        return r;
    endfunction

    // Drives one word LSB-first, one bit per cycle; entered and left just after a falling edge.
    task automatic send_word(input logic [28:0] w, input int ws_bit, input int latch_bit, input bit expect_cap);
        for (int b = 1; b <= 29; b++) begin
            CM        = w[b-1];
            WORD_SYNC = (b == ws_bit);
            LATCH     = (b == latch_bit);
            if ((b == latch_bit) && expect_cap) sb_q.push_back(w);
            @(negedge CLOCK);
        end
        CM = 1'b0; WORD_SYNC = 1'b0; LATCH = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({BITT, SYNCED, VALID, SYNC_ERR} !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_status: got BITT=%0d SYNCED=%b VALID=%b SYNC_ERR=%b, want all 0", BITT, SYNCED, VALID, SYNC_ERR);
        end
        checks++;
        if ({ID, T, BP, N, C, S, D, PREFIX} !== 29'd0 || DS !== 1'b0 || S_OH !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_fields: got fields=%h DS=%b S_OH=%h, want 0", {ID, T, BP, N, C, S, D, PREFIX}, DS, S_OH);
        end
    endtask

    task automatic test_sync_acquire;
        // Nine idle cycles (with a premature LATCH), then WORD_SYNC in the tenth.
        for (int i = 1; i <= 9; i++) begin
            LATCH = (i == 5);
            @(negedge CLOCK);
            checks++;
            if (BITT !== 5'd0) begin
                errors++;
                $display("[TB] FAIL presync_bitt: got %0d, want 0", BITT);
            end
        end
        checks++;
        if (SYNCED !== 1'b0) begin
            errors++;
            $display("[TB] FAIL presync_synced: got %b, want 0", SYNCED);
        end
        WORD_SYNC = 1'b1; LATCH = 1'b1;
        @(negedge CLOCK);
        WORD_SYNC = 1'b0; LATCH = 1'b0;
        checks++;
        if (BITT !== 5'd1 || SYNCED !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sync_first: got BITT=%0d SYNCED=%b, want 1/1", BITT, SYNCED);
        end
        for (int b = 1; b <= 29; b++) begin
            if (b == 29) begin
                checks++;
                if (BITT !== 5'd29) begin
                    errors++;
                    $display("[TB] FAIL sync_bitt29: got %0d, want 29", BITT);
                end
            end
            WORD_SYNC = (b == 29);
            @(negedge CLOCK);
        end
        WORD_SYNC = 1'b0;
        checks++;
        if (BITT !== 5'd1 || SYNC_ERR !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sync_wrap: got BITT=%0d SYNC_ERR=%b, want 1/0", BITT, SYNC_ERR);
        end
    endtask

    task automatic test_field_capture;
        logic [32:0] sp;
        w1 = make_word(1'b0, 5'd31, 5'd5, 2'd2, 7'h40, 1'b1, 7'h15, 1'b1);
        send_word(w1, 29, 29, 1'b1);
        checks++;
        if (VALID !== 1'b1) begin errors++; $display("[TB] FAIL cap_valid: got %b, want 1", VALID); end
        checks++;
        if (D !== 5'd31) begin errors++; $display("[TB] FAIL cap_D: got %0d, want 31", D); end
        checks++;
        if (S !== 5'd5) begin errors++; $display("[TB] FAIL cap_S: got %0d, want 5", S); end
        checks++;
        if (C !== 2'd2) begin errors++; $display("[TB] FAIL cap_C: got %0d, want 2", C); end
        checks++;
        if (N !== 7'h40) begin errors++; $display("[TB] FAIL cap_N: got %h, want 40", N); end
        checks++;
        if (T !== 7'h15) begin errors++; $display("[TB] FAIL cap_T: got %h, want 15", T); end
        checks++;
        if ({PREFIX, BP, ID} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL cap_flags: got PREFIX/BP/ID=%b%b%b, want 011", PREFIX, BP, ID);
        end
`ifdef G15_SPECIAL_DECODE_EN
        sp = {1'b1, 32'h0000_0020};
`else
        sp = '0;
`endif
        checks++;
        if ({DS, S_OH} !== sp) begin
            errors++;
            $display("[TB] FAIL cap_special: got DS=%b S_OH=%h, want DS=%b S_OH=%h", DS, S_OH, sp[32], sp[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        w2 = make_word(1'b1, 5'd3, 5'd17, 2'd1, 7'h2A, 1'b0, 7'h7F, 1'b0);
        w3 = 29'($urandom);
        send_word(w2, 29, 29, 1'b1);
        checks++;
        if (VALID !== 1'b1 || {ID, T, BP, N, C, S, D, PREFIX} !== w2) begin
            errors++;
            $display("[TB] FAIL b2b_first: got VALID=%b word=%h, want 1/%h", VALID, {ID, T, BP, N, C, S, D, PREFIX}, w2);
        end
        send_word(w3, 29, 29, 1'b1);
        checks++;
        if (VALID !== 1'b1 || {ID, T, BP, N, C, S, D, PREFIX} !== w3) begin
            errors++;
            $display("[TB] FAIL b2b_second: got VALID=%b word=%h, want 1/%h", VALID, {ID, T, BP, N, C, S, D, PREFIX}, w3);
        end
    endtask

    task automatic test_ignored_latch;
        w4 = make_word(1'b1, 5'd31, 5'd9, 2'd3, 7'h11, 1'b1, 7'h01, 1'b0);
        send_word(w4, 29, 15, 1'b0);
        checks++;
        if (VALID !== 1'b0 || {ID, T, BP, N, C, S, D, PREFIX} !== w3) begin
            errors++;
            $display("[TB] FAIL ignored_latch: got VALID=%b word=%h, want 0/%h", VALID, {ID, T, BP, N, C, S, D, PREFIX}, w3);
        end
    endtask

    task automatic test_sync_slip;
        for (int b = 1; b <= 20; b++) begin
            WORD_SYNC = (b == 20);
            @(negedge CLOCK);
        end
        WORD_SYNC = 1'b0;
        checks++;
        if (SYNC_ERR !== 1'b1 || BITT !== 5'd1) begin
            errors++;
            $display("[TB] FAIL slip_detect: got SYNC_ERR=%b BITT=%0d, want 1/1", SYNC_ERR, BITT);
        end
        w5 = make_word(1'b0, 5'd31, 5'd0, 2'd0, 7'h05, 1'b0, 7'h33, 1'b1);
        send_word(w5, 29, 29, 1'b1);
        checks++;
        if (VALID !== 1'b1 || {ID, T, BP, N, C, S, D, PREFIX} !== w5 || SYNC_ERR !== 1'b1) begin
            errors++;
            $display("[TB] FAIL slip_recapture: got VALID=%b word=%h SYNC_ERR=%b, want 1/%h/1",
                     VALID, {ID, T, BP, N, C, S, D, PREFIX}, SYNC_ERR, w5);
        end
    endtask

    task automatic test_reset_midword;
        logic [32:0] sp;
        for (int b = 1; b <= 11; b++) @(negedge CLOCK);
        checks++;
        if (BITT !== 5'd12) begin errors++; $display("[TB] FAIL pre_reset_bitt: got %0d, want 12", BITT); end
        #1 rst_n = 1'b0;
        #1;
        test_reset;
        @(negedge CLOCK);
        @(negedge CLOCK);
        rst_n = 1'b1;
        // LATCH held high without WORD_SYNC must neither count nor capture.
        for (int i = 0; i < 5; i++) begin
            LATCH = 1'b1;
            CM    = 1'b1;
            @(negedge CLOCK);
            checks++;
            if (BITT !== 5'd0 || SYNCED !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset_idle: got BITT=%0d SYNCED=%b, want 0/0", BITT, SYNCED);
            end
        end
        LATCH = 1'b0; CM = 1'b0;
        WORD_SYNC = 1'b1;
        @(negedge CLOCK);
        WORD_SYNC = 1'b0;
        w6 = make_word(1'b1, 5'd31, 5'd31, 2'd1, 7'h7F, 1'b1, 7'h00, 1'b1);
        send_word(w6, 29, 29, 1'b1);
        sp = special_of(w6);
        checks++;
        if (VALID !== 1'b1 || {ID, T, BP, N, C, S, D, PREFIX} !== w6 || {DS, S_OH} !== sp || SYNC_ERR !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_capture: got VALID=%b word=%h DS=%b S_OH=%h SYNC_ERR=%b, want 1/%h/%b/%h/0",
                     VALID, {ID, T, BP, N, C, S, D, PREFIX}, DS, S_OH, SYNC_ERR, w6, sp[32], sp[31:0]);
        end
    endtask

    initial begin
        rst_n = 1'b0; CM = 1'b0; WORD_SYNC = 1'b0; LATCH = 1'b0;
        // Scoreboard monitor: every VALID pulse must match the oldest expected capture.
        fork
            forever begin
                logic [28:0] exp_w;
                logic [32:0] exp_sp;
                @(negedge CLOCK);
                if (rst_n && VALID) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL sb_unexpected_valid: got VALID=1 word=%h, want no capture", {ID, T, BP, N, C, S, D, PREFIX});
                    end else begin
                        exp_w  = sb_q.pop_front();
                        exp_sp = special_of(exp_w);
                        if ({ID, T, BP, N, C, S, D, PREFIX} !== exp_w || {DS, S_OH} !== exp_sp) begin
                            errors++;
                            $display("[TB] FAIL sb_word: got word=%h DS=%b S_OH=%h, want %h/%b/%h",
                                     {ID, T, BP, N, C, S, D, PREFIX}, DS, S_OH, exp_w, exp_sp[32], exp_sp[31:0]);
                        end
                    end
                end
            end
        join_none
        repeat (3) @(negedge CLOCK);
        test_reset;
        rst_n = 1'b1;
        test_sync_acquire;
        test_field_capture;
        test_back_to_back;
        test_ignored_latch;
        test_sync_slip;
        test_reset_midword;
        repeat (3) @(negedge CLOCK);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d captures never seen on VALID, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_decode.md
# cmd_decode

Serial-to-parallel decoder for the 29-bit command word on the command register track (CM) of the G-15 control gate. The control gate writes and recirculates CM bit-serially. This block is the reader at the other end of that track. Each word time it shifts CM in LSB-first, tracks bit time against a word-sync strobe, and, on a latch request, presents the static command fields in parallel to the operation decoders.

## Interface
- No parameters.
- CLOCK  in  1  bit-time clock, one CM bit per rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- CM  in  1  serial command bit; bit 1 arrives first.
- WORD_SYNC  in  1  asserted during the bit-29 cycle of every word.
- LATCH  in  1  request to capture the word completing in this cycle (RC & T29 equivalent).
- BITT  out  5  current bit time: 1..29, or 0 when unsynchronized.
- SYNCED  out  1  bit counter aligned to WORD_SYNC.
- VALID  out  1  one-cycle pulse after the fields update.
- PREFIX  out  1  double-precision prefix (bit 1).
- D  out  5  destination (bits 2-6).
- S  out  5  source (bits 7-11).
- C  out  2  characteristic (bits 12-13).
- N  out  7  next-command location (bits 14-20).
- BP  out  1  breakpoint flag (bit 21).
- T  out  7  timing number (bits 22-28).
- ID  out  1  immediate/deferred (bit 29).
- DS  out  1  special command, D == 31 (see Configuration).
- S_OH  out  32  one-hot decode of S for special commands (see Configuration).
- SYNC_ERR  out  1  sticky flag: WORD_SYNC arrived at the wrong bit time.

## Operation
- Shift register SR[28:0]. Every cycle SR <= {CM, SR[28:1]}. After bit 29 is shifted in, SR[0] holds bit 1.
- Bit counter:
  - Reset value is 0.
  - When WORD_SYNC = 1 the next value is 1, regardless of the current value.
  - Otherwise, when non-zero, the counter counts 1..29 and wraps from 29 to 1.
  - Otherwise it stays at 0.
- SYNCED is set by the first WORD_SYNC. It is cleared only by reset.
- Sync error: SYNC_ERR is set when WORD_SYNC = 1 while SYNCED = 1 and BITT != 29. It is cleared only by reset. The counter realigns anyway.
- Capture:
  - The capture condition is LATCH & SYNCED & (BITT == 29).
  - On the next edge the fields load from the word completed by that edge, i.e. {CM, SR[28:1]}.
  - A LATCH at any other bit time, or while unsynchronized, is ignored. Fields hold and no VALID is produced.
- Field values are little-endian within each field; the lowest-numbered bit is the LSB. Example: D = word bits 6..2, with bit 2 as D[0].
- Fields hold their values until the next capture.
- Simultaneous WORD_SYNC and LATCH at BITT == 29: capture proceeds normally and the counter goes to 1.

## Timing
- Reset values: BITT = 0, SYNCED = 0, VALID = 0, SYNC_ERR = 0, and all field outputs, DS and S_OH are 0. SR clears to 0.
- Latency: fields update on the edge ending the bit-29 cycle in which LATCH was sampled. VALID is high for exactly the following cycle, which is bit time 1 of the next word.
- Back-to-back LATCH on consecutive words yields a VALID pulse every 29 cycles.
- Reset asserted mid-word clears everything immediately (asynchronously). After release, no capture occurs before a fresh WORD_SYNC.
- All outputs are registered; there is no combinational path from the inputs to any output.

## Configuration
- Macro: G15_SPECIAL_DECODE_EN.
- Defined:
  - DS is registered alongside the fields and equals (captured D == 31).
  - S_OH[S] = 1 when DS = 1; otherwise S_OH = 0.
  - Both update on the same edge as the fields.
- Undefined: DS and S_OH are tied to 0, and no decode logic is present.

## Test plan
- Sync acquisition: reset, then drive WORD_SYNC at cycle 10 and every 29 cycles after -> BITT = 1 at cycle 11, 29 at cycle 39; SYNCED = 1; SYNC_ERR = 0.
- Field capture: serialize a word with PREFIX=0, D=31, S=5, C=2, N=0x40, T=0x15, BP=1, ID=1, with LATCH at bit 29 -> next cycle D=31, S=5, C=2, N=0x40, T=0x15, BP=1, ID=1, VALID=1 for one cycle. With the macro defined, DS=1 and S_OH=0x0000_0020.
- Ignored latch: LATCH at BITT=15, and LATCH before the first WORD_SYNC -> fields unchanged, VALID stays 0.
- Sync slip: WORD_SYNC at BITT=20 -> SYNC_ERR=1 (sticky), BITT=1 next cycle; a later correct capture still succeeds.
- Reset mid-word: assert rst_n low at BITT=12 after a capture -> all outputs 0 immediately; BITT stays 0 until WORD_SYNC.
- Macro off: same word as the field-capture test -> identical fields, DS=0, S_OH=0.
